sync_fifo: RTL and testbench

Single-clock, parametrised FIFO, the single-domain counterpart of the team's dual-clock FIFO. It is used wherever producer and consumer share a clock. It adds full-depth usability, a fill-level output, programmable almost-full and almost-empty thresholds, and selectable standard or first-word-fall-through (FWFT) read mode. It also provides sticky overflow and underflow error flags. It sits between same-clock pipeline stages and in front of CDC blocks as a rate buffer.

---
 rtl/sync_fifo.sv | 145 ++++++++++++++
 tb/tb_sync_fifo.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock parametrised FIFO with fill level, programmable
// almost-full / almost-empty thresholds, standard or first-word-fall-through
// read mode, and sticky overflow / underflow error flags.
//
// Ports:
//   clk, rst_n                  clock (rising edge), async active-low reset
//   wr_data, wr_en              write word and write request
//   wr_full, wr_almost_full     level == DEPTH, level >= AFULL_THRESH
//   rd_en                       read request (FWFT: acknowledge of head word)
//   rd_data, rd_valid           read word and its valid qualifier
//   rd_empty, rd_almost_empty   level == 0, level <= AEMPTY_THRESH
//   fill_level                  number of stored words, 0..DEPTH
//   err_clr                     synchronous clear of the sticky error flags
//   overflow, underflow         sticky error flags
module sync_fifo #(
    parameter int DATA_WIDTH    = 4,
    parameter int ADDR_WIDTH    = 8,
    parameter int FWFT          = 0,
    parameter int AFULL_THRESH  = 2**ADDR_WIDTH - 2,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_en,
    output logic                  wr_full,
    output logic                  wr_almost_full,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  rd_empty,
    output logic                  rd_almost_empty,
    output logic [ADDR_WIDTH:0]   fill_level,
    input  logic                  err_clr,
    output logic                  overflow,
    output logic                  underflow
);
    localparam int DEPTH = 2**ADDR_WIDTH;

    // Parameter legality, rejected at elaboration.
    if (ADDR_WIDTH < 2 || ADDR_WIDTH > 12) begin : g_bad_addr_width
        $error("sync_fifo: ADDR_WIDTH must be in 2..12");
    end
    if (DATA_WIDTH < 1) begin : g_bad_data_width
        $error("sync_fifo: DATA_WIDTH must be >= 1");
    end
    if (FWFT != 0 && FWFT != 1) begin : g_bad_fwft
        $error("sync_fifo: FWFT must be 0 or 1");
    end
    if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_afull
        $error("sync_fifo: AFULL_THRESH must be in 1..DEPTH");
    end
    if (AEMPTY_THRESH < 0 || AEMPTY_THRESH > DEPTH - 1) begin : g_bad_aempty
        $error("sync_fifo: AEMPTY_THRESH must be in 0..DEPTH-1");
    end

    localparam logic [ADDR_WIDTH:0] LVL_FULL = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] LVL_AF   = (ADDR_WIDTH+1)'(AFULL_THRESH);
    localparam logic [ADDR_WIDTH:0] LVL_AE   = (ADDR_WIDTH+1)'(AEMPTY_THRESH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   level;
    logic [ADDR_WIDTH:0]   level_nxt;
    logic                  wa;
    logic                  ra;

    // Acceptance uses the registered flags, so wr_en/rd_en never reach a
    // flag combinationally; both sides decide on the pre-edge state.
    assign wa = wr_en & ~wr_full;
    assign ra = rd_en & ~rd_empty;

    always_comb begin
        level_nxt = level;
        if (wa && !ra) begin
            level_nxt = level + (ADDR_WIDTH+1)'(1);
        end else if (ra && !wa) begin
            level_nxt = level - (ADDR_WIDTH+1)'(1);
        end
    end

    // Storage is not reset.
    always_ff @(posedge clk) begin
        if (wa) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            level           <= '0;
            wr_full         <= 1'b0;
            wr_almost_full  <= 1'b0;
            rd_empty        <= 1'b1;
            rd_almost_empty <= 1'b1;
            overflow        <= 1'b0;
            underflow       <= 1'b0;
        end else begin
            if (wa) begin
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            end
            if (ra) begin
                rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
            end
            level           <= level_nxt;
            wr_full         <= (level_nxt == LVL_FULL);
            wr_almost_full  <= (level_nxt >= LVL_AF);
            rd_empty        <= (level_nxt == '0);
            rd_almost_empty <= (level_nxt <= LVL_AE);
            // A new error in the same cycle as err_clr keeps the flag set.
            overflow  <= (wr_en & wr_full)  | (overflow  & ~err_clr);
            underflow <= (rd_en & rd_empty) | (underflow & ~err_clr);
        end
    end

    assign fill_level = level;

    if (FWFT == 0) begin : g_std
        logic [DATA_WIDTH-1:0] rd_data_q;
        logic                  rd_valid_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rd_data_q  <= '0;
                rd_valid_q <= 1'b0;
            end else begin
                rd_valid_q <= ra;
                if (ra) begin
                    rd_data_q <= mem[rd_ptr];
                end
            end
        end

        assign rd_data  = rd_data_q;
        assign rd_valid = rd_valid_q;
    end else begin : g_fwft
        // Head word straight from the array. Masked to zero while empty so
        // the output is stable and matches the reset value.
        assign rd_data  = rd_empty ? '0 : mem[rd_ptr];
        assign rd_valid = ~rd_empty;
    end
endmodule

// File: tb/tb_sync_fifo.sv
// Testbench for sync_fifo: a standard-mode and an FWFT-mode instance (depth 8)
// share all stimulus; a queue-based reference model predicts flags, levels
// and read data, and a negedge monitor compares the DUT outputs against it.
module tb_sync_fifo;
    localparam int DW    = 4;
    localparam int AW    = 3;
    localparam int DEPTH = 8;
    localparam int AF    = 6;
    localparam int AE    = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_en = 1'b0;
    logic          rd_en = 1'b0;
    logic          err_clr = 1'b0;

    logic          s_full, s_af, s_valid, s_empty, s_ae, s_ovf, s_udf;
    logic [DW-1:0] s_data;
    logic [AW:0]   s_fill;
    logic          f_full, f_af, f_valid, f_empty, f_ae, f_ovf, f_udf;
    logic [DW-1:0] f_data;
    logic [AW:0]   f_fill;

    int total = 0;
    int bad   = 0;

    // Reference model state.
    logic [DW-1:0] mq[$];     // stored words, oldest first
    logic [DW-1:0] sb[$];     // standard-mode words due on rd_data
    logic          m_ovf = 1'b0;
    logic          m_udf = 1'b0;
    logic          m_rv  = 1'b0;

    always #5 clk = ~clk;

    sync_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(0),
                .AFULL_THRESH(AF), .AEMPTY_THRESH(AE)) u_std (
        .clk(clk), .rst_n(rst_n), .wr_data(wr_data), .wr_en(wr_en),
        .wr_full(s_full), .wr_almost_full(s_af), .rd_en(rd_en),
        .rd_data(s_data), .rd_valid(s_valid), .rd_empty(s_empty),
        .rd_almost_empty(s_ae), .fill_level(s_fill), .err_clr(err_clr),
        .overflow(s_ovf), .underflow(s_udf));

    sync_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(1),
                .AFULL_THRESH(AF), .AEMPTY_THRESH(AE)) u_fwft (
        .clk(clk), .rst_n(rst_n), .wr_data(wr_data), .wr_en(wr_en),
        .wr_full(f_full), .wr_almost_full(f_af), .rd_en(rd_en),
        .rd_data(f_data), .rd_valid(f_valid), .rd_empty(f_empty),
        .rd_almost_empty(f_ae), .fill_level(f_fill), .err_clr(err_clr),
        .overflow(f_ovf), .underflow(f_udf));

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; the model follows the FIFO rules on the
    // pre-edge occupancy.
    task automatic step(input logic we, input logic [DW-1:0] wd,
                        input logic re, input logic ec);
        int  lvl;
        bit  wacc, racc;
        wr_en = we; wr_data = wd; rd_en = re; err_clr = ec;
        lvl  = mq.size();
        wacc = we && (lvl < DEPTH);
        racc = re && (lvl > 0);
        @(posedge clk);
        #1;
        if (racc) sb.push_back(mq.pop_front());
        if (wacc) mq.push_back(wd);
        m_ovf = (we && lvl == DEPTH) ? 1'b1 : (ec ? 1'b0 : m_ovf);
        m_udf = (re && lvl == 0)     ? 1'b1 : (ec ? 1'b0 : m_udf);
        m_rv  = racc;
        wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0;
    endtask

    // Monitor: every falling edge compares both instances with the model.
    always @(negedge clk) begin
        int lvl;
        lvl = mq.size();
        chk("s_fill",  int'(s_fill),  lvl);
        chk("f_fill",  int'(f_fill),  lvl);
        chk("s_full",  int'(s_full),  int'(lvl == DEPTH));
        chk("f_full",  int'(f_full),  int'(lvl == DEPTH));
        chk("s_afull", int'(s_af),    int'(lvl >= AF));
        chk("f_afull", int'(f_af),    int'(lvl >= AF));
        chk("s_empty", int'(s_empty), int'(lvl == 0));
        chk("f_empty", int'(f_empty), int'(lvl == 0));
        chk("s_aempty", int'(s_ae),   int'(lvl <= AE));
        chk("f_aempty", int'(f_ae),   int'(lvl <= AE));
        chk("s_ovf",   int'(s_ovf),   int'(m_ovf));
        chk("f_ovf",   int'(f_ovf),   int'(m_ovf));
        chk("s_udf",   int'(s_udf),   int'(m_udf));
        chk("f_udf",   int'(f_udf),   int'(m_udf));
        chk("s_valid", int'(s_valid), int'(m_rv));
        chk("f_valid", int'(f_valid), int'(lvl > 0));
        if (lvl > 0) chk("f_head", int'(f_data), int'(mq[0]));
        if (s_valid) begin
            if (sb.size() == 0) chk("s_sb_empty", int'(s_valid), 0);
            else                chk("s_data", int'(s_data), int'(sb.pop_front()));
        end
    end

    task automatic model_reset();
        mq.delete(); sb.delete();
        m_ovf = 1'b0; m_udf = 1'b0; m_rv = 1'b0;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_s_empty", int'(s_empty), 1);
        chk("rst_s_data",  int'(s_data),  0);
        chk("rst_f_data",  int'(f_data),  0);
        chk("rst_s_valid", int'(s_valid), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: fill with 1..8, ninth write overflows, drain in order.
        for (int i = 1; i <= 8; i++) step(1'b1, DW'(i), 1'b0, 1'b0);
        chk("t1_full", int'(s_full), 1);
        step(1'b1, 4'hF, 1'b0, 1'b0);
        chk("t1_ovf", int'(s_ovf), 1);
        for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1);
        chk("t1_empty", int'(s_empty), 1);

        // 2: simultaneous write/read from empty, then clear.
        step(1'b1, 4'h5, 1'b1, 1'b0);
        chk("t2_udf", int'(s_udf), 1);
        chk("t2_fill", int'(s_fill), 1);
        step(1'b0, '0, 1'b0, 1'b1);
        chk("t2_clr", int'(s_udf), 0);

        // 3: fill to 8, simultaneous write/read when full.
        for (int i = 0; i < 7; i++) step(1'b1, DW'(i + 9), 1'b0, 1'b0);
        step(1'b1, 4'h3, 1'b1, 1'b0);
        chk("t3_fill", int'(s_fill), 7);
        chk("t3_data", int'(s_data), 5);
        for (int i = 0; i < 7; i++) step(1'b0, '0, 1'b1, 1'b1);

        // 4: stream 20 words at level 3 across the pointer wrap.
        for (int i = 0; i < 3; i++) step(1'b1, DW'(i), 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b1, DW'(i + 3), 1'b1, 1'b0);
        chk("t4_fill", int'(s_fill), 3);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0);

        // 5: FWFT head visible without rd_en.
        step(1'b1, 4'hA, 1'b0, 1'b0);
        chk("t5_fdata", int'(f_data), 4'hA);
        chk("t5_fvalid", int'(f_valid), 1);
        step(1'b0, '0, 1'b1, 1'b0);
        chk("t5_fempty", int'(f_empty), 1);

        // Random traffic, including err_clr against fresh errors.
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 99) < 55), DW'($urandom),
                 1'($urandom_range(0, 99) < 50), 1'($urandom_range(0, 99) < 8));
        while (mq.size() > 0) step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1);

        // 6: async reset between edges at level 5.
        for (int i = 0; i < 5; i++) step(1'b1, DW'(i + 1), 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("t6_empty", int'(s_empty), 1);
        chk("t6_fill",  int'(s_fill),  0);
        chk("t6_fempty", int'(f_empty), 1);
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        step(1'b1, 4'hC, 1'b0, 1'b0);
        chk("t6_fhead", int'(f_data), 4'hC);
        step(1'b0, '0, 1'b1, 1'b0);
        chk("t6_sdata", int'(s_data), 4'hC);
        step(1'b0, '0, 1'b0, 1'b0);
        chk("t6_sb_left", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
